// File: rtl/mesh_tb_l2_banked_mem.sv
// Word-interleaved banked L2 memory model: per-bank round-robin arbitration across tile ports,
// fixed one-cycle response latency, out-of-range accesses answered with an error flag.
module mesh_tb_l2_banked_mem #(
  parameter int unsigned N_MEM_BANKS  = 32,
  parameter int unsigned N_WORDS_BANK = 4096,
  parameter int unsigned N_TILES      = 2,
  parameter logic [31:0] L2_BASE      = 32'h1C00_0000,
  parameter logic [31:0] ERR_RDATA    = 32'hBADCAB1E
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_TILES-1:0]       req_i,
  output logic [N_TILES-1:0]       gnt_o,
  input  logic [N_TILES-1:0][31:0] addr_i,
  input  logic [N_TILES-1:0]       we_i,
  input  logic [N_TILES-1:0][3:0]  be_i,
  input  logic [N_TILES-1:0][31:0] wdata_i,
  output logic [N_TILES-1:0]       rvalid_o,
  output logic [N_TILES-1:0][31:0] rdata_o,
  output logic [N_TILES-1:0]       err_o
);

  localparam int unsigned BB = $clog2(N_MEM_BANKS);
  localparam int unsigned RB = $clog2(N_WORDS_BANK);
  localparam int unsigned TW = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [32:0] MemBytes = 33'(longint'(N_MEM_BANKS) * N_WORDS_BANK * 4);
  localparam logic [TW:0] NTiles = (TW + 1)'(N_TILES);

  logic [N_TILES-1:0][31:0]   off;
  logic [N_TILES-1:0][BB-1:0] bank;
  logic [N_TILES-1:0][RB-1:0] row;
  logic [N_TILES-1:0]         in_range;
  logic [N_TILES-1:0]         gnt;

  logic [N_MEM_BANKS-1:0]         bank_vld;
  logic [N_MEM_BANKS-1:0][TW-1:0] bank_tile;
  logic [N_MEM_BANKS-1:0][TW-1:0] rr_q, rr_d;

  logic [31:0] mem_q [N_MEM_BANKS][N_WORDS_BANK];

  logic [N_TILES-1:0]       rvalid_q, err_q;
  logic [N_TILES-1:0][31:0] rdata_q;

  always_comb begin
    for (int t = 0; t < N_TILES; t++) begin
      off[t]      = addr_i[t] - L2_BASE;
      bank[t]     = off[t][2 +: BB];
      row[t]      = off[t][2 + BB +: RB];
      in_range[t] = (addr_i[t] >= L2_BASE) && ({1'b0, off[t]} < MemBytes);
    end
  end

  // Per bank, scan tiles starting at the RR pointer and take the first in-range requester.
  always_comb begin
    logic [TW:0] idx;
    idx       = '0;
    gnt       = '0;
    bank_vld  = '0;
    bank_tile = '0;
    rr_d      = rr_q;
    for (int b = 0; b < N_MEM_BANKS; b++) begin
      for (int i = 0; i < N_TILES; i++) begin
        idx = {1'b0, rr_q[b]} + (TW + 1)'(i);
        if (idx >= NTiles) idx = idx - NTiles;
        if (!bank_vld[b] && req_i[idx[TW-1:0]] && in_range[idx[TW-1:0]] &&
            (bank[idx[TW-1:0]] == BB'(b))) begin
          bank_vld[b]           = 1'b1;
          bank_tile[b]          = idx[TW-1:0];
          gnt[idx[TW-1:0]]      = 1'b1;
          rr_d[b]               = (idx == NTiles - 1'b1) ? '0 : idx[TW-1:0] + 1'b1;
        end
      end
    end
  end

  // Out-of-range requests bypass the banks and are always accepted.
  assign gnt_o = rst_i ? '0 : (gnt | (req_i & ~in_range));

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < N_MEM_BANKS; b++) begin
      if (!rst_i && bank_vld[b] && we_i[bank_tile[b]]) begin
        for (int k = 0; k < 4; k++) begin
          if (be_i[bank_tile[b]][k]) begin
            mem_q[b][row[bank_tile[b]]][8*k +: 8] <= wdata_i[bank_tile[b]][8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      for (int t = 0; t < N_TILES; t++) begin
        rvalid_q[t] <= gnt_o[t];
        err_q[t]    <= gnt_o[t] & ~in_range[t];
        if (!gnt_o[t] || we_i[t]) rdata_q[t] <= '0;
        else if (!in_range[t])    rdata_q[t] <= ERR_RDATA;
        else                      rdata_q[t] <= mem_q[bank[t]][row[t]];
      end
    end
  end

  always_comb begin
    rvalid_o = rvalid_q & ~{N_TILES{rst_i}};
    err_o    = err_q & rvalid_o;
    for (int t = 0; t < N_TILES; t++) begin
      rdata_o[t] = rvalid_o[t] ? rdata_q[t] : '0;
    end
  end

endmodule

// File: tb/tb_mesh_tb_l2_banked_mem.sv
// Bench for mesh_tb_l2_banked_mem: directed vector table, reset corner sequence, then random
// traffic compared against a word-level reference model.
module tb_mesh_tb_l2_banked_mem;

  localparam logic [31:0] B   = 32'h1C00_0000;
  localparam logic [31:0] BAD = 32'hBADCAB1E;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we, gnt, rvalid, err;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][3:0] be;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mesh_tb_l2_banked_mem dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err)
  );

  typedef struct {
    logic             rst;
    logic [1:0]       req, we;
    logic [1:0][31:0] a, wd;
    logic [3:0]       be0;
    logic [1:0]       gnt, rv, err;
    logic [31:0]      rd0, rd1;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] w,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [3:0] be0, input logic [31:0] wd0,
                              input logic [31:0] wd1, input logic [1:0] g,
                              input logic [1:0] rv, input logic [1:0] e,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.rst = r; v.req = rq; v.we = w; v.a[0] = a0; v.a[1] = a1; v.be0 = be0;
    v.wd[0] = wd0; v.wd[1] = wd1; v.gnt = g; v.rv = rv; v.err = e; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    rst = v.rst; req = v.req; we = v.we; addr = v.a; wdata = v.wd;
    be[0] = v.be0; be[1] = 4'hF;
    #4;
    chk({nm, ".gnt"}, 32'(gnt), 32'(v.gnt));
    chk({nm, ".rvalid"}, 32'(rvalid), 32'(v.rv));
    chk({nm, ".err"}, 32'(err), 32'(v.err));
    chk({nm, ".rdata0"}, rdata[0], v.rd0);
    chk({nm, ".rdata1"}, rdata[1], v.rd1);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  // Reference model state
  logic [31:0] mm [int];
  int          rr_m [32];
  logic [1:0]  exp_rv, exp_err, pend;
  logic [31:0] exp_rd [2];

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    @(posedge clk);
    #1;

    // Reset, then directed table; rr starts at 0 for every bank.
    tbl.push_back(mk(1, 2'b11, 2'b00, B, B+4, 4'hF, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(1, 2'b00, 2'b00, B, B, 4'hF, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, B, B, 4'hF, 32'hDEADBEEF, 0,
                     2'b01, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b10, B, B+32'h84, 4'hF, 0, 32'h11223344,
                     2'b11, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b01, B+32'h84, B, 4'b0101, 32'hAABBCCDD, 0,
                     2'b01, 2'b11, 2'b00, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 2'b11, 2'b10, B+32'h84, B+32'hC, 4'hF, 0, 32'h0C0C0C0C,
                     2'b11, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 32'h1C08_0000, 32'h1BFF_FFFC, 4'hF, 0, 0,
                     2'b11, 2'b11, 2'b00, 32'h11BB33DD, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, B+32'hC, B+32'hC, 4'hF, 0, 0,
                     2'b01, 2'b11, 2'b11, BAD, BAD));
    tbl.push_back(mk(0, 2'b11, 2'b00, B+32'hC, B+32'hC, 4'hF, 0, 0,
                     2'b10, 2'b01, 2'b00, 32'h0C0C0C0C, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, B+32'hC, B+32'hC, 4'hF, 0, 0,
                     2'b01, 2'b10, 2'b00, 0, 32'h0C0C0C0C));
    tbl.push_back(mk(0, 2'b00, 2'b00, B, B, 4'hF, 0, 0, 2'b00, 2'b01, 2'b00, 32'h0C0C0C0C, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, B, B, 4'hF, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset one cycle after a granted read; the write in the reset cycle must be lost.
    apply(mk(0, 2'b01, 2'b00, B, B, 4'hF, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0), "rst_a");
    apply(mk(1, 2'b01, 2'b01, B, B, 4'hF, 32'h12345678, 0, 2'b00, 2'b00, 2'b00, 0, 0), "rst_b");
    apply(mk(0, 2'b11, 2'b00, B+32'hC, B+32'hC, 4'hF, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0), "rst_c");
    apply(mk(0, 2'b11, 2'b00, B, B+32'hC, 4'hF, 0, 0, 2'b11, 2'b01, 2'b00, 32'h0C0C0C0C, 0),
          "rst_d");
    apply(mk(0, 2'b00, 2'b00, B, B, 4'hF, 0, 0, 2'b00, 2'b11, 2'b00, 32'hDEADBEEF, 32'h0C0C0C0C),
          "rst_e");

    // Random phase from a fresh reset.
    apply(mk(1, 2'b00, 2'b00, B, B, 4'hF, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0), "rnd_rst");
    for (int b = 0; b < 32; b++) rr_m[b] = 0;
    exp_rv = '0; exp_err = '0; exp_rd[0] = '0; exp_rd[1] = '0; pend = '0;
    rst = 1'b0;

    for (int cyc = 0; cyc < 408; cyc++) begin
      logic [1:0] mg;
      logic       inr [2];
      int         bk [2], key [2];
      logic [31:0] off;
      for (int t = 0; t < 2; t++) begin
        if (cyc < 8) begin
          req[t] = (t == 0); we[t] = 1'b1; be[t] = 4'hF; wdata[t] = $urandom;
          addr[t] = B + 32'((cyc / 4) * 128 + (cyc % 4) * 4);
        end else if (!pend[t]) begin
          req[t] = ($urandom_range(0, 9) < 7);
          we[t] = $urandom_range(0, 1);
          be[t] = 4'($urandom_range(0, 15));
          wdata[t] = $urandom;
          case ($urandom_range(0, 9))
            0:       addr[t] = 32'h1C08_0000 + 32'($urandom_range(0, 7) * 4);
            1:       addr[t] = 32'h1BFF_FFFC;
            default: addr[t] = B + 32'($urandom_range(0, 1) * 128 + $urandom_range(0, 3) * 4);
          endcase
          addr[t][1:0] = 2'($urandom_range(0, 3));
        end
      end
      #4;
      mg = '0;
      for (int t = 0; t < 2; t++) begin
        off = addr[t] - B;
        inr[t] = (addr[t] >= B) && (off < 32'd524288);
        bk[t] = int'((off >> 2) % 32);
        key[t] = int'(off >> 2);
        if (req[t] && !inr[t]) mg[t] = 1'b1;
      end
      for (int b = 0; b < 32; b++) begin
        for (int k = 0; k < 2; k++) begin
          int t;
          t = (rr_m[b] + k) % 2;
          if (req[t] && inr[t] && bk[t] == b && !(mg[0] && bk[0] == b && inr[0])
              && !(mg[1] && bk[1] == b && inr[1])) begin
            mg[t] = 1'b1;
            rr_m[b] = (t + 1) % 2;
          end
        end
      end
      chk($sformatf("rnd%0d.gnt", cyc), 32'(gnt), 32'(mg));
      chk($sformatf("rnd%0d.rvalid", cyc), 32'(rvalid), 32'(exp_rv));
      chk($sformatf("rnd%0d.err", cyc), 32'(err), 32'(exp_err));
      chk($sformatf("rnd%0d.rdata0", cyc), rdata[0], exp_rd[0]);
      chk($sformatf("rnd%0d.rdata1", cyc), rdata[1], exp_rd[1]);
      for (int t = 0; t < 2; t++) begin
        exp_rv[t]  = mg[t];
        exp_err[t] = mg[t] && !inr[t];
        if (!mg[t] || we[t]) exp_rd[t] = '0;
        else if (!inr[t])    exp_rd[t] = BAD;
        else                 exp_rd[t] = mm[key[t]];
      end
      for (int t = 0; t < 2; t++) begin
        if (mg[t] && inr[t] && we[t]) begin
          logic [31:0] w;
          w = mm.exists(key[t]) ? mm[key[t]] : 32'h0;
          for (int k = 0; k < 4; k++) if (be[t][k]) w[8*k +: 8] = wdata[t][8*k +: 8];
          mm[key[t]] = w;
        end
        pend[t] = req[t] && !mg[t];
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mesh_tb_l2_banked_mem.md
Name: mesh_tb_l2_banked_mem

Overview:
- Behavioural, synthesizable word-interleaved banked L2 memory model for the RedMulE mesh testbench.
- Sits directly downstream of the mesh tiles' external (OBI-style) data ports. Accepts one request per tile per cycle.
- Arbitrates round-robin per bank and returns read data with fixed 1-cycle latency.
- Its sizing defaults match the mesh testbench package: 32 banks x 4096 words, 2 tiles.

Parameters:
- N_MEM_BANKS, 32: number of banks; power of two, >=2.
- N_WORDS_BANK, 4096: 32-bit words per bank; power of two.
- N_TILES, 2: number of requesting tile ports; >=1.
- L2_BASE, 32'h1C00_0000: byte base address of the memory.
- ERR_RDATA, 32'hBADCAB1E: rdata returned on an out-of-range access.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N_TILES  per-tile request valid.
- gnt_o  out  N_TILES  per-tile grant; combinational from the same-cycle requests and the RR state.
- addr_i  in  N_TILES x 32  byte address; bits [1:0] are ignored.
- we_i  in  N_TILES  1 = write, 0 = read.
- be_i  in  N_TILES x 4  byte enables; writes only.
- wdata_i  in  N_TILES x 32  write data.
- rvalid_o  out  N_TILES  response valid, one cycle after the grant, for reads and writes.
- rdata_o  out  N_TILES x 32  read data; 0 on writes.
- err_o  out  N_TILES  out-of-range flag, qualified by rvalid_o.

Behaviour:
- Address decode, with off = addr - L2_BASE and BB = log2(N_MEM_BANKS):
  - bank = off[2 +: BB].
  - row = off[2+BB +: log2(N_WORDS_BANK)].
  - in_range = (addr >= L2_BASE) && (off < N_MEM_BANKS*N_WORDS_BANK*4).
- Out-of-range request:
  - Always granted in the same cycle; takes no bank slot and does not move any RR pointer.
  - Next cycle: rvalid=1, err=1, rdata=ERR_RDATA for reads, 0 for writes.
  - Memory is unmodified.
- Per-bank arbitration:
  - Each bank has an RR pointer rr[b] in [0, N_TILES-1].
  - Among the in-range requesters targeting bank b, grant the first tile at or after rr[b], wrapping modulo N_TILES.
  - At most one grant per bank per cycle. A tile targets exactly one bank, so it gets at most one grant.
  - On any grant at bank b: rr[b] <= granted_tile+1, wrapping N_TILES-1 -> 0.
  - Without contention the pointer still advances on the grant.
  - Losing requesters see gnt=0. They must hold req and their fields stable until granted; the block does not check this.
- Access on the grant edge:
  - Write: bytes with be set are updated; be=4'b0000 writes nothing but still responds.
  - Read: data is captured on the grant edge and presented the next cycle.
- Ordering:
  - A write at cycle t followed by a read of the same word at t+1 returns the new data.
  - A same-cycle read and write to the same word cannot occur, because one bank grants once per cycle.
- Response pipeline:
  - Per tile, the registers rvalid/err/rdata are loaded every cycle.
  - rvalid_o[t] = the tile's registered gnt & req from the previous cycle.
  - rdata_o and err_o are 0 whenever rvalid_o=0.
  - Back-to-back grants give back-to-back rvalids; throughput is 1 per tile per cycle.
- Reset:
  - While rst_i=1, all gnt_o, rvalid_o, rdata_o and err_o are 0, and rr[*] <= 0.
  - Memory array contents are not reset; reads before any write return X.
  - Reset asserted mid-transaction: a response due in the next cycle is dropped (rvalid stays 0), and a write granted in the reset cycle does not occur.
- Simultaneous events:
  - Requests to different banks are all granted in the same cycle.
  - An out-of-range request and an in-range request are granted together.

Test Plan:
- Single write then read. Tile0 writes 32'hDEADBEEF be=4'hF at 0x1C00_0000; next cycle it reads the same address. Expected: gnt=1 both cycles; read rvalid at the following cycle with rdata=32'hDEADBEEF, err=0.
- Partial write. Preload 32'h11223344 at 0x1C00_0084 (bank 1, row 1), then write 32'hAABBCCDD with be=4'b0101, then read. Expected: rdata=32'h11BB33DD.
- Bank conflict round-robin. Tiles 0 and 1 both read bank 3 continuously from reset. Expected grants alternate T0,T1,T0,T1; each tile's rvalid rate is 50%; a loser's gnt=0 while it holds its request.
- No conflict. Tile0 accesses bank 0 and tile1 accesses bank 1 in the same cycle. Expected: both granted every cycle, both rvalid every cycle after the first, and rr[0] and rr[1] both advance.
- Out-of-range. Read at 0x1C08_0000 (offset 512 KiB, exactly one past the end). Expected: gnt=1, next cycle err=1, rdata=32'hBADCAB1E, no RR change. A read at 0x1BFF_FFFC also gives err=1.
- Reset mid-operation. Tile0's read is granted at cycle t and rst_i=1 at t+1. Expected: rvalid_o=0 at t+1 and rr reset to 0. A write granted in a reset cycle leaves the previously written value 32'hDEADBEEF intact on a later read.
